// File: rtl/bpu_pkg.sv
// Shared types and default sizing for the branch-predictor update controller.
package bpu_pkg;

  localparam int NUM_TABLES = 4;
  localparam int ENTRY_NUM  = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        correct;
  } bpu_upd_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } bpu_state_t;

endpackage

// File: rtl/bpu_upd_fifo.sv
// Small power-of-two FIFO buffering resolved-branch updates; flush drops all entries.
module bpu_upd_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  bpu_upd_t din,
  output bpu_upd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  bpu_upd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  // Storage array; not reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/bpu_update_ctrl.sv
// Serializes resolved-branch updates into the predictor and walks an invalidate
// sweep over every table entry after reset or flush.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | issuing one invalidate per cycle, (table,idx) stepping up
//   ST_RUN   | forwarding buffered updates to the predictor
module bpu_update_ctrl #(
  parameter int NUM_TABLES = bpu_pkg::NUM_TABLES,
  parameter int ENTRY_NUM  = bpu_pkg::ENTRY_NUM,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ex_valid,
  output logic                          ex_ready,
  input  logic [31:0]                   ex_pc,
  input  logic                          ex_taken,
  input  logic [31:0]                   ex_target,
  input  logic                          ex_correct,
  input  logic                          flush_req,
  output logic                          upd_valid,
  input  logic                          upd_ready,
  output logic [31:0]                   upd_pc,
  output logic                          upd_taken,
  output logic [31:0]                   upd_target,
  output logic                          clr_valid,
  output logic [$clog2(NUM_TABLES)-1:0] clr_table,
  output logic [$clog2(ENTRY_NUM)-1:0]  clr_idx,
  output logic                          busy,
  output logic [31:0]                   total_cnt,
  output logic [31:0]                   correct_cnt
);

  import bpu_pkg::*;

  localparam int TW = $clog2(NUM_TABLES);
  localparam int IW = $clog2(ENTRY_NUM);
  localparam logic [TW-1:0] TBL_LAST = TW'(NUM_TABLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(ENTRY_NUM - 1);

  bpu_state_t    state_q, state_d;
  logic [TW-1:0] tbl_q, tbl_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   total_q, correct_q;

  bpu_upd_t      fifo_din, fifo_head;
  logic          fifo_full, fifo_empty;
  logic          push, pop;

  assign fifo_din = '{pc: ex_pc, taken: ex_taken, target: ex_target, correct: ex_correct};

  // Acceptance never looks at upd_ready; a flush cycle refuses new work.
  assign ex_ready  = !reset && !fifo_full && !flush_req;
  assign push      = ex_valid && ex_ready;
  // Entries being dropped by a flush are never offered downstream.
  assign upd_valid = !reset && (state_q == ST_RUN) && !fifo_empty && !flush_req;
  assign pop       = upd_valid && upd_ready;

  assign upd_pc      = fifo_head.pc;
  assign upd_taken   = fifo_head.taken;
  assign upd_target  = fifo_head.target;
  assign clr_table   = tbl_q;
  assign clr_idx     = idx_q;
  assign total_cnt   = total_q;
  assign correct_cnt = correct_q;

  bpu_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush_req),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State and sweep position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      tbl_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep sequencing: idx fastest, then table; flush restarts from (0,0).
  always_comb begin
    state_d   = state_q;
    tbl_d     = tbl_q;
    idx_d     = idx_q;
    clr_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_valid = 1'b1;
        busy      = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          if (tbl_q == TBL_LAST) begin
            tbl_d   = '0;
            state_d = ST_RUN;
          end else begin
            tbl_d = tbl_q + TW'(1);
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
    if (flush_req) begin
      state_d = ST_CLEAR;
      tbl_d   = '0;
      idx_d   = '0;
    end
  end

  // Retired-update statistics, counted only on real handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_q   <= '0;
      correct_q <= '0;
    end else if (pop) begin
      total_q <= total_q + 32'd1;
      if (fifo_head.correct) correct_q <= correct_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Bench for bpu_update_ctrl: scenario tasks plus a queue-based reference model.
module tb_bpu_update_ctrl;
  import bpu_pkg::*;

  localparam int NT = 4;
  localparam int EN = 64;
  localparam int DP = 4;

  logic        clk, reset;
  logic        ex_valid, ex_ready, ex_taken, ex_correct, flush_req;
  logic [31:0] ex_pc, ex_target;
  logic        upd_valid, upd_ready, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic        clr_valid, busy;
  logic [1:0]  clr_table;
  logic [5:0]  clr_idx;
  logic [31:0] total_cnt, correct_cnt;

  int checks = 0;
  int errors = 0;

  bpu_upd_t    q[$];
  bit          m_clear;
  int          m_pos;
  logic [31:0] m_total, m_correct;

  bpu_update_ctrl #(.NUM_TABLES(NT), .ENTRY_NUM(EN), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_correct(ex_correct), .flush_req(flush_req),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .clr_valid(clr_valid), .clr_table(clr_table), .clr_idx(clr_idx),
    .busy(busy), .total_cnt(total_cnt), .correct_cnt(correct_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: compare every output against the model, then advance both.
  task automatic tick();
    logic       exp_rdy, exp_uv;
    logic [1:0] exp_tbl;
    logic [5:0] exp_idx;
    bpu_upd_t   h;
    #1;
    if (reset) begin
      exp_rdy = 1'b0;
      exp_uv  = 1'b0;
    end else begin
      exp_rdy = (q.size() < DP) && !flush_req;
      exp_uv  = !m_clear && (q.size() > 0) && !flush_req;
    end
    checks++;
    if (ex_ready !== exp_rdy) begin
      errors++; $display("FAIL ex_ready: got %b expected %b at %0t", ex_ready, exp_rdy, $time);
    end
    checks++;
    if (upd_valid !== exp_uv) begin
      errors++; $display("FAIL upd_valid: got %b expected %b at %0t", upd_valid, exp_uv, $time);
    end
    if (exp_uv) begin
      h = q[0];
      checks++;
      if ({upd_pc, upd_taken, upd_target} !== {h.pc, h.taken, h.target}) begin
        errors++;
        $display("FAIL upd_fields: got %h/%b/%h expected %h/%b/%h at %0t",
                 upd_pc, upd_taken, upd_target, h.pc, h.taken, h.target, $time);
      end
    end
    if (!reset) begin
      checks++;
      if (clr_valid !== m_clear || busy !== m_clear) begin
        errors++; $display("FAIL clr_valid_busy: got %b/%b expected %b at %0t", clr_valid, busy, m_clear, $time);
      end
      if (m_clear) begin
        exp_tbl = 2'(m_pos / EN);
        exp_idx = 6'(m_pos % EN);
        checks++;
        if (clr_table !== exp_tbl || clr_idx !== exp_idx) begin
          errors++; $display("FAIL clr_pos: got (%0d,%0d) expected (%0d,%0d) at %0t",
                             clr_table, clr_idx, exp_tbl, exp_idx, $time);
        end
      end
      checks++;
      if (total_cnt !== m_total || correct_cnt !== m_correct) begin
        errors++; $display("FAIL counters: got %h/%h expected %h/%h at %0t",
                           total_cnt, correct_cnt, m_total, m_correct, $time);
      end
    end
    if (reset) begin
      q.delete(); m_clear = 1'b1; m_pos = 0; m_total = '0; m_correct = '0;
    end else if (flush_req) begin
      q.delete(); m_clear = 1'b1; m_pos = 0;
    end else begin
      if (exp_uv && upd_ready) begin
        h = q.pop_front();
        m_total += 32'd1;
        if (h.correct) m_correct += 32'd1;
      end
      if (ex_valid && exp_rdy)
        q.push_back('{pc: ex_pc, taken: ex_taken, target: ex_target, correct: ex_correct});
      if (m_clear) begin
        m_pos++;
        if (m_pos == NT * EN) begin m_clear = 1'b0; m_pos = 0; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (upd_valid !== 1'b0 || ex_ready !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got upd_valid=%b ex_ready=%b required 0/0", upd_valid, ex_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (clr_valid !== 1'b1 || clr_table !== 2'd0 || clr_idx !== 6'd0) begin
      errors++; $display("FAIL reset_walk_start: got v=%b (%0d,%0d) required 1 (0,0)", clr_valid, clr_table, clr_idx);
    end
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (clr_valid !== 1'b1) break;
      n++;
      tick();
    end
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL clear_length: got %0d cycles required 256", n);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_after_clear: got %b required 0", busy);
    end
  endtask

  task automatic test_single();
    logic [31:0] tgt;
    tgt = $urandom;
    upd_ready = 1'b1;
    ex_valid = 1'b1; ex_pc = 32'h8000_0010; ex_taken = 1'b1; ex_target = tgt; ex_correct = 1'b1;
    #1;
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready: got %b required 1", ex_ready);
    end
    tick();
    ex_valid = 1'b0;
    #1;
    checks++;
    if (upd_valid !== 1'b1 || upd_pc !== 32'h8000_0010 || upd_taken !== 1'b1 || upd_target !== tgt) begin
      errors++; $display("FAIL single_out: got v=%b pc=%h t=%b tgt=%h required 1/80000010/1/%h",
                         upd_valid, upd_pc, upd_taken, upd_target, tgt);
    end
    tick();
    checks++;
    if (total_cnt !== 32'd1 || correct_cnt !== 32'd1) begin
      errors++; $display("FAIL single_counts: got %0d/%0d required 1/1", total_cnt, correct_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pcs [5];
    int popped;
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pcs[i] = $urandom;
      ex_valid = 1'b1; ex_pc = pcs[i]; ex_taken = 1'($urandom); ex_target = $urandom; ex_correct = 1'($urandom);
      #1;
      checks++;
      if (ex_ready !== (i < 4)) begin
        errors++; $display("FAIL bp_ready_%0d: got %b required %b", i, ex_ready, (i < 4));
      end
      if (i < 4) tick();
    end
    upd_ready = 1'b1;
    popped = 0;
    for (int c = 0; c < 20 && popped < 5; c++) begin
      #1;
      if (upd_valid) begin
        checks++;
        if (upd_pc !== pcs[popped]) begin
          errors++; $display("FAIL bp_order_%0d: got %h required %h", popped, upd_pc, pcs[popped]);
        end
        popped++;
      end
      if (ex_valid && ex_ready) begin
        tick();
        ex_valid = 1'b0;
      end else begin
        tick();
      end
    end
    checks++;
    if (popped != 5) begin
      errors++; $display("FAIL bp_drain: got %0d pops required 5", popped);
    end
  endtask

  task automatic test_flush();
    logic [31:0] t0, c0;
    upd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1; ex_pc = $urandom; ex_taken = 1'($urandom); ex_target = $urandom; ex_correct = 1'b1;
      tick();
    end
    ex_valid = 1'b0;
    t0 = m_total; c0 = m_correct;
    flush_req = 1'b1;
    #1;
    checks++;
    if (ex_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b required 0", ex_ready);
    end
    tick();
    flush_req = 1'b0;
    upd_ready = 1'b1;
    #1;
    checks++;
    if (upd_valid !== 1'b0 || clr_valid !== 1'b1 || clr_table !== 2'd0 || clr_idx !== 6'd0) begin
      errors++; $display("FAIL flush_restart: got uv=%b cv=%b (%0d,%0d) required 0 1 (0,0)",
                         upd_valid, clr_valid, clr_table, clr_idx);
    end
    checks++;
    if (total_cnt !== t0 || correct_cnt !== c0) begin
      errors++; $display("FAIL flush_counts: got %h/%h required %h/%h", total_cnt, correct_cnt, t0, c0);
    end
    for (int i = 0; i < 256; i++) tick();
    checks++;
    if (busy !== 1'b0 || upd_valid !== 1'b0) begin
      errors++; $display("FAIL flush_end: got busy=%b uv=%b required 0/0", busy, upd_valid);
    end
  endtask

  task automatic test_flush_mid_clear();
    logic [31:0] pv;
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    for (int i = 0; i < 300 && m_pos != 2 * EN + 17; i++) tick();
    #1;
    checks++;
    if (clr_table !== 2'd2 || clr_idx !== 6'd17) begin
      errors++; $display("FAIL mid_pos: got (%0d,%0d) required (2,17)", clr_table, clr_idx);
    end
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    #1;
    checks++;
    if (clr_valid !== 1'b1 || clr_table !== 2'd0 || clr_idx !== 6'd0) begin
      errors++; $display("FAIL mid_restart: got v=%b (%0d,%0d) required 1 (0,0)", clr_valid, clr_table, clr_idx);
    end
    pv = $urandom;
    ex_valid = 1'b1; ex_pc = pv; ex_taken = 1'b0; ex_target = $urandom; ex_correct = 1'b1;
    upd_ready = 1'b1;
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 300 && m_clear; i++) begin
      #1;
      checks++;
      if (upd_valid !== 1'b0) begin
        errors++; $display("FAIL mid_held: got upd_valid=%b required 0 during clear", upd_valid);
      end
      tick();
    end
    #1;
    checks++;
    if (upd_valid !== 1'b1 || upd_pc !== pv) begin
      errors++; $display("FAIL mid_emit: got v=%b pc=%h required 1/%h", upd_valid, upd_pc, pv);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] c0;
    force dut.total_q = 32'hFFFF_FFFE;
    #1;
    release dut.total_q;
    m_total = 32'hFFFF_FFFE;
    c0 = m_correct;
    upd_ready = 1'b1;
    ex_valid = 1'b1; ex_taken = 1'b1; ex_correct = 1'b0;
    ex_pc = $urandom; ex_target = $urandom; tick();
    ex_pc = $urandom; ex_target = $urandom; tick();
    ex_valid = 1'b0;
    tick(); tick();
    checks++;
    if (total_cnt !== 32'h0 || correct_cnt !== c0) begin
      errors++; $display("FAIL wrap: got %h/%h required 00000000/%h", total_cnt, correct_cnt, c0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      ex_valid   = 1'($urandom_range(0, 1));
      ex_pc      = $urandom;
      ex_taken   = 1'($urandom);
      ex_target  = $urandom;
      ex_correct = 1'($urandom);
      upd_ready  = ($urandom_range(0, 3) != 0);
      flush_req  = ($urandom_range(0, 299) == 0);
      reset      = ($urandom_range(0, 999) == 0);
      tick();
    end
    ex_valid = 1'b0; flush_req = 1'b0; reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
    ex_correct = 1'b0; flush_req = 1'b0; upd_ready = 1'b0;
    q.delete(); m_clear = 1'b1; m_pos = 0; m_total = '0; m_correct = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_backpressure();
    test_flush();
    test_flush_mid_clear();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
